// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 slave port: default sizes, FSM state type
// and the idle levels the input synchronizers start from.
package spi_slave_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic SSN_IDLE  = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a delay register
// that turns the synchronized level into single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned STAGES   = 2,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q;
    logic              lvl;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl    = sync_q[STAGES-1];
    assign rise_o = lvl & ~prev_q;
    assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first slave, oversampled by the system clock,
// with a one-word RX output register and a one-word TX holding register.
module spi_slave_port
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              SSn,
    output logic              MISO,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    input  logic              RX_READY,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              OVERRUN,
    output logic              UNDERRUN,
    input  logic              CLR_ERR
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic sck_rise, sck_fall, ssn_rise, ssn_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic mosi_s;

    state_e state_q, state_d;
    logic   load_start, abort, do_rise, do_fall, miso;

    logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
    logic              tx_full_q, tx_full_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d, rx_word;
    logic              rx_valid_q, rx_valid_d;
    logic              ovr_q, ovr_d, udr_q, udr_d;
    logic              tx_load, tx_take, word_done, rx_consume, ovr_set;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(SCK_IDLE)) u_sck_sync (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .d_i    (SCK),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(SSN_IDLE)) u_ssn_sync (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .d_i    (SSn),
        .rise_o (ssn_rise),
        .fall_o (ssn_fall)
    );

    always_comb begin
        mosi_sync_d    = mosi_sync_q;
        mosi_sync_d[0] = MOSI;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            mosi_sync_d[i] = mosi_sync_q[i-1];
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE}};
        end else begin
            state_q     <= state_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (ssn_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (ssn_rise) state_d = ST_IDLE;
        endcase
    end

    // A deselect in the same cycle as an SCK edge wins: the edge is dropped.
    always_comb begin
        load_start = 1'b0;
        abort      = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        miso       = 1'b0;
        unique case (state_q)
            ST_IDLE:   load_start = ssn_fall;
            ST_ACTIVE: begin
                abort   = ssn_rise;
                do_rise = sck_rise & ~ssn_rise;
                do_fall = sck_fall & ~ssn_rise;
                miso    = tx_shift_q[DATA_W-1];
            end
        endcase
    end

    always_comb begin
        tx_load    = load_start | (do_fall & (cnt_q == '0));
        tx_take    = TX_VALID & ~tx_full_q;
        rx_word    = {rx_shift_q, mosi_s};
        word_done  = do_rise & (cnt_q == CNT_LAST);
        rx_consume = rx_valid_q & RX_READY;

        tx_shift_d = tx_shift_q;
        if (abort) begin
            tx_shift_d = '0;
        end else if (tx_load) begin
            tx_shift_d = tx_full_q ? tx_hold_q : '0;
        end else if (do_fall) begin
            tx_shift_d = tx_shift_q << 1;
        end
        // A write landing in the same cycle as a load refills the holding register.
        tx_full_d = (tx_full_q & ~tx_load) | tx_take;
        tx_hold_d = tx_take ? TX_DATA : tx_hold_q;

        rx_shift_d = rx_shift_q;
        cnt_d      = cnt_q;
        if (abort || load_start) begin
            rx_shift_d = '0;
            cnt_d      = '0;
        end else if (do_rise) begin
            rx_shift_d = rx_word[DATA_W-2:0];
            cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_consume;
        ovr_set    = 1'b0;
        if (word_done) begin
            if (!rx_valid_q || RX_READY) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        ovr_d = ovr_set | (ovr_q & ~CLR_ERR);
        udr_d = (tx_load & ~tx_full_q) | (udr_q & ~CLR_ERR);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            rx_shift_q <= '0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            udr_q      <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
            rx_shift_q <= rx_shift_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            udr_q      <= udr_d;
        end
    end

    assign MISO     = miso;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign TX_READY = ~tx_full_q;
    assign OVERRUN  = ovr_q;
    assign UNDERRUN = udr_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Drives the slave as an SPI mode-0 master at CLK/8 and compares it against a
// word-level model of the RX/TX registers and sticky error flags.
module tb_spi_slave_port;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       SCK = 1'b0;
    logic       MOSI = 1'b0;
    logic       SSn = 1'b1;
    logic       RX_READY = 1'b0;
    logic       TX_VALID = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [7:0] TX_DATA = '0;
    logic       MISO, RX_VALID, TX_READY, OVERRUN, UNDERRUN;
    logic [7:0] RX_DATA;

    spi_slave_port #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .SSn      (SSn),
        .MISO     (MISO),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .OVERRUN  (OVERRUN),
        .UNDERRUN (UNDERRUN),
        .CLR_ERR  (CLR_ERR)
    );

    always #5 CLK = ~CLK;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned hs_cnt = 0;
    logic        settled = 1'b0;

    logic       m_rx_valid, m_ovr, m_udr, m_full;
    logic [7:0] m_rx_data, m_hold;
    logic [7:0] mo_w [4];
    logic [7:0] got_w [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic model_reset();
        m_rx_valid = 1'b0; m_ovr = 1'b0; m_udr = 1'b0; m_full = 1'b0;
        m_rx_data = '0; m_hold = '0;
    endtask

    // Word handed to the shifter whenever a new word starts (select or word boundary).
    task automatic model_load(output logic [7:0] w);
        if (m_full) begin
            w = m_hold;
            m_full = 1'b0;
        end else begin
            w = 8'h00;
            m_udr = 1'b1;
        end
    endtask

    task automatic model_rx(input logic [7:0] w, input bit ready_held);
        if (ready_held) begin
            m_rx_data = w;
            m_rx_valid = 1'b0;
        end else if (!m_rx_valid) begin
            m_rx_data = w;
            m_rx_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    always @(negedge CLK) begin
        if (settled) begin
            chk("rx_valid", 32'(RX_VALID), 32'(m_rx_valid));
            chk("rx_data", 32'(RX_DATA), 32'(m_rx_data));
            chk("overrun", 32'(OVERRUN), 32'(m_ovr));
            chk("underrun", 32'(UNDERRUN), 32'(m_udr));
            chk("tx_ready", 32'(TX_READY), 32'(!m_full));
            chk("miso_idle", 32'(MISO), 32'd0);
        end
    end

    always @(posedge CLK) begin
        if (RX_VALID && RX_READY) hs_cnt <= hs_cnt + 1;
    end

    task automatic do_word(input logic [7:0] mo, input logic [7:0] exp_m, input int nbits,
                           output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            wait_clk(4);
            got[7-i] = MISO;
            chk("miso_bit", 32'(MISO), 32'(exp_m[7-i]));
            SCK = 1'b1;
            wait_clk(4);
            SCK = 1'b0;
        end
    endtask

    task automatic frame(input int n, input int last_bits, input bit ready_held);
        logic [7:0] exp_m, g;
        int nb;
        settled = 1'b0;
        if (ready_held) begin
            RX_READY = 1'b1;
            m_rx_valid = 1'b0;
        end
        SSn = 1'b0;
        model_load(exp_m);
        wait_clk(8);
        for (int k = 0; k < n; k++) begin
            nb = (k == n - 1) ? last_bits : 8;
            do_word(mo_w[k], exp_m, nb, g);
            got_w[k] = g;
            if (nb == 8) begin
                model_rx(mo_w[k], ready_held);
                model_load(exp_m);
            end
        end
        wait_clk(4);
        SSn = 1'b1;
        MOSI = 1'b0;
        wait_clk(8);
        RX_READY = 1'b0;
        wait_clk(2);
        settled = 1'b1;
    endtask

    task automatic consume();
        settled = 1'b0;
        RX_READY = 1'b1;
        wait_clk(1);
        RX_READY = 1'b0;
        m_rx_valid = 1'b0;
        wait_clk(1);
        settled = 1'b1;
    endtask

    task automatic tx_write(input logic [7:0] d);
        settled = 1'b0;
        TX_DATA = d;
        TX_VALID = 1'b1;
        wait_clk(1);
        TX_VALID = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = d;
        end
        wait_clk(1);
        settled = 1'b1;
    endtask

    task automatic clr_err();
        settled = 1'b0;
        CLR_ERR = 1'b1;
        wait_clk(1);
        CLR_ERR = 1'b0;
        m_ovr = 1'b0;
        m_udr = 1'b0;
        wait_clk(1);
        settled = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, 32'(MISO), 32'd0);
        chk({tag, "_rx_valid"}, 32'(RX_VALID), 32'd0);
        chk({tag, "_rx_data"}, 32'(RX_DATA), 32'd0);
        chk({tag, "_tx_ready"}, 32'(TX_READY), 32'd1);
        chk({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
        chk({tag, "_underrun"}, 32'(UNDERRUN), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_m, g;
        int unsigned hs0;

        model_reset();
        wait_clk(3);
        check_reset_outputs("reset");
        RSTn = 1'b1;
        wait_clk(2);
        settled = 1'b1;

        // Preloaded 0xA5 returned while 0x3C is received.
        tx_write(8'hA5);
        mo_w[0] = 8'h3C;
        frame(1, 8, 0);
        chk("a5_miso_word", 32'(got_w[0]), 32'h0000_00A5);
        chk("a5_rx_data", 32'(RX_DATA), 32'h0000_003C);
        chk("a5_rx_valid", 32'(RX_VALID), 32'd1);
        consume();
        clr_err();

        // Second word dropped while the first is still unconsumed.
        mo_w[0] = 8'h11; mo_w[1] = 8'h22;
        frame(2, 8, 0);
        chk("ovr_rx_data", 32'(RX_DATA), 32'h0000_0011);
        chk("ovr_flag", 32'(OVERRUN), 32'd1);
        clr_err();
        chk("ovr_cleared", 32'(OVERRUN), 32'd0);
        consume();

        // No TX preload: zeros returned and underrun flagged.
        mo_w[0] = 8'h77;
        frame(1, 8, 0);
        chk("udr_miso_word", 32'(got_w[0]), 32'd0);
        chk("udr_flag", 32'(UNDERRUN), 32'd1);
        chk("udr_tx_ready", 32'(TX_READY), 32'd1);
        consume();
        clr_err();

        // Deselect after five bits, then a clean frame.
        mo_w[0] = 8'hF3;
        frame(1, 5, 0);
        chk("abort_rx_valid", 32'(RX_VALID), 32'd0);
        mo_w[0] = 8'h81;
        frame(1, 8, 0);
        chk("after_abort_rx", 32'(RX_DATA), 32'h0000_0081);
        consume();
        clr_err();

        // Back-to-back words with the consumer always ready.
        mo_w[0] = 8'h01; mo_w[1] = 8'h02; mo_w[2] = 8'h03; mo_w[3] = 8'h04;
        hs0 = hs_cnt;
        frame(4, 8, 1);
        chk("b2b_pulses", hs_cnt - hs0, 32'd4);
        chk("b2b_overrun", 32'(OVERRUN), 32'd0);
        chk("b2b_last", 32'(RX_DATA), 32'h0000_0004);
        clr_err();

        // Reset in the middle of a word.
        tx_write(8'hC3);
        settled = 1'b0;
        SSn = 1'b0;
        model_load(exp_m);
        wait_clk(8);
        do_word(8'hFF, exp_m, 3, g);
        RSTn = 1'b0;
        wait_clk(1);
        check_reset_outputs("midrst");
        SSn = 1'b1;
        wait_clk(2);
        RSTn = 1'b1;
        model_reset();
        wait_clk(4);
        settled = 1'b1;
        mo_w[0] = 8'h5A;
        frame(1, 8, 0);
        chk("post_rst_rx", 32'(RX_DATA), 32'h0000_005A);
        chk("post_rst_valid", 32'(RX_VALID), 32'd1);

        for (int it = 0; it < 30; it++) begin
            int unsigned op;
            int unsigned nw;
            op = $urandom_range(0, 5);
            case (op)
                0: tx_write(8'($urandom));
                1: consume();
                2: clr_err();
                default: begin
                    nw = $urandom_range(1, 3);
                    for (int k = 0; k < 4; k++) mo_w[k] = 8'($urandom);
                    frame(int'(nw), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 8,
                          $urandom_range(0, 3) == 0);
                end
            endcase
        end

        settled = 1'b0;
        wait_clk(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
